fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding-request fetch FSM and a
// 2-entry instruction buffer in front of decode, with branch redirect and flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0002_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req is accepted in the cycle it is high, and the response is
  // one imem_valid strobe at least one cycle later; a decode transfer occurs in any
  // cycle with if_valid && id_ready && !br_taken.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [1:0] FULL = FIFO_DEPTH[1:0];

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [1:0]  count_q;
  logic [31:0] pc0_q, ins0_q, pc1_q, ins1_q;
  logic        push, pop;

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != 2'd0);
  assign if_pc     = pc0_q;
  assign if_instr  = ins0_q;
  assign dbg_state = state_q;
  assign pop       = if_valid && id_ready && !br_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      FETCH: begin
        if (count_q < FULL && !br_taken && !rst) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // A redirect orphans the in-flight response; DISCARD swallows it if late.
        if (br_taken)        state_d = imem_valid ? FETCH : DISCARD;
        else if (imem_valid) begin
          push    = 1'b1;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (imem_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc_q <= RESET_PC;
    else if (br_taken) pc_q <= {br_target[31:2], 2'b00};
    else if (push)     pc_q <= pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      pc0_q   <= 32'd0;
      ins0_q  <= 32'd0;
      pc1_q   <= 32'd0;
      ins1_q  <= 32'd0;
    end else if (br_taken) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_q  <= pc_q;
            ins0_q <= imem_rdata;
          end else begin
            pc1_q  <= pc_q;
            ins1_q <= imem_rdata;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          pc0_q   <= pc1_q;
          ins0_q  <= ins1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Head leaves while the new word arrives; keep arrival order.
          if (count_q == 2'd1) begin
            pc0_q  <= pc_q;
            ins0_q <= imem_rdata;
          end else begin
            pc0_q  <= pc1_q;
            ins0_q <= ins1_q;
            pc1_q  <= pc_q;
            ins1_q <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
